// File: rtl/keypad4x4_scan_pkg.sv
// Shared constants for the 4x4 keypad scanner: key map, FSM encoding, idle column pattern.
package keypad4x4_scan_pkg;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  typedef logic [1:0] fsm_state_t;

  localparam logic [3:0] ROW_IDLE = 4'hF;

  // KEYMAP[row][col]; each 16-bit group is one row, col3 in the top nibble.
  localparam logic [3:0][3:0][3:0] KEYMAP = {16'hDF0E, 16'hC987, 16'hB654, 16'hA321};

  function automatic logic [1:0] low_col(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    if (!col[0])      idx = 2'd0;
    else if (!col[1]) idx = 2'd1;
    else if (!col[2]) idx = 2'd2;
    else if (!col[3]) idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] row);
    logic [1:0] idx;
    case (row)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Tick-qualified saturating run-length counter; done flags the tick that completes TICKS samples.
module keypad_debounce_cnt #(
  parameter int unsigned TICKS = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic start,
  input  logic match,
  output logic done
);

  localparam logic [3:0] LAST = 4'(TICKS - 1);
  localparam logic [3:0] FULL = 4'(TICKS);

  logic [3:0] count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= 4'd0;
    end else if (tick) begin
      if (start)
        count <= 4'd1;
      else if (match) begin
        if (count != FULL)
          count <= count + 4'd1;
      end else
        count <= 4'd0;
    end
  end

  // The starting sample already counts as one, so TICKS==1 completes on start.
  assign done = tick & (start ? (TICKS == 1) : (match & (count == LAST)));

endmodule

// File: rtl/keypad4x4_scan.sv
// 4x4 active-low keypad scanner: row scan, debounce, hex encode, 32-bit entry shift register.
module keypad4x4_scan
  import keypad4x4_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV_W     = 15,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Cs,
  input  logic        Clr,
  input  logic [3:0]  I_Col,
  output logic [3:0]  O_Row,
  output logic [3:0]  O_Key,
  output logic        O_Valid,
  output logic        O_Key_Pulse,
  output logic [31:0] O_Data
);

  localparam logic [SCAN_DIV_W-1:0] PRESC_ONE = {{(SCAN_DIV_W-1){1'b0}}, 1'b1};

  logic [3:0]            col_meta;
  logic [3:0]            col_s;
  logic [SCAN_DIV_W-1:0] presc;
  logic                  tick;
  fsm_state_t            state;
  logic [1:0]            key_row;
  logic [1:0]            key_col;
  logic                  col_idle;
  logic [1:0]            cur_row;
  logic [1:0]            cur_col;
  logic                  cnt_start;
  logic                  cnt_match;
  logic                  cnt_done;
  logic                  accept;
  logic [3:0]            acc_code;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      col_meta <= ROW_IDLE;
      col_s    <= ROW_IDLE;
      presc    <= '0;
    end else begin
      col_meta <= I_Col;
      col_s    <= col_meta;
      presc    <= presc + PRESC_ONE;
    end
  end

  assign tick     = &presc;
  assign col_idle = (col_s == ROW_IDLE);
  assign cur_row  = row_index(O_Row);
  assign cur_col  = low_col(col_s);

  always_comb begin
    cnt_start = 1'b0;
    cnt_match = 1'b0;
    case (state)
      ST_SCAN:     cnt_start = !col_idle;
      ST_DEBOUNCE: cnt_match = !col_idle && (cur_col == key_col);
      ST_HELD:     cnt_start = col_idle;
      default:     cnt_match = col_idle;
    endcase
  end

  keypad_debounce_cnt #(
    .TICKS (DEBOUNCE_TICKS)
  ) u_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .tick  (tick),
    .start (cnt_start),
    .match (cnt_match),
    .done  (cnt_done)
  );

  // In SCAN the key position is not latched yet, so encode from the live row/column.
  assign accept   = cnt_done && ((state == ST_SCAN) || (state == ST_DEBOUNCE));
  assign acc_code = (state == ST_SCAN) ? KEYMAP[cur_row][cur_col] : KEYMAP[key_row][key_col];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_SCAN;
      O_Row   <= 4'b1110;
      key_row <= 2'd0;
      key_col <= 2'd0;
    end else if (tick) begin
      case (state)
        ST_SCAN: begin
          if (col_idle)
            O_Row <= {O_Row[2:0], O_Row[3]};
          else begin
            key_row <= cur_row;
            key_col <= cur_col;
            state   <= cnt_done ? ST_HELD : ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (cnt_match) begin
            if (cnt_done)
              state <= ST_HELD;
          end else
            state <= ST_SCAN;
        end
        ST_HELD: begin
          if (col_idle)
            state <= ST_RELEASE;
        end
        default: begin
          if (!col_idle)
            state <= ST_HELD;
          else if (cnt_done) begin
            state <= ST_SCAN;
            O_Row <= {O_Row[2:0], O_Row[3]};
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      O_Key       <= 4'h0;
      O_Valid     <= 1'b0;
      O_Key_Pulse <= 1'b0;
      O_Data      <= 32'h0;
    end else begin
      O_Key_Pulse <= accept;
      if (accept) begin
        O_Key   <= acc_code;
        O_Valid <= 1'b1;
        O_Data  <= Clr ? {28'h0, acc_code} : {O_Data[27:0], acc_code};
      end else begin
        if (Cs)
          O_Valid <= 1'b0;
        if (Clr)
          O_Data <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_keypad4x4_scan.sv
// Directed bench for keypad4x4_scan with a keypad model driving I_Col from O_Row and the pressed set.
module tb_keypad4x4_scan;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Cs;
  logic        Clr;
  logic [3:0]  I_Col;
  logic [3:0]  O_Row;
  logic [3:0]  O_Key;
  logic        O_Valid;
  logic        O_Key_Pulse;
  logic [31:0] O_Data;

  logic [15:0] keys;
  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  int          base;
  bit          ok;
  logic [3:0]  row_seq [4];
  logic [3:0]  seq_code [9];
  int          seq_r [9];
  int          seq_c [9];

  keypad4x4_scan #(
    .SCAN_DIV_W     (2),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Cs          (Cs),
    .Clr         (Clr),
    .I_Col       (I_Col),
    .O_Row       (O_Row),
    .O_Key       (O_Key),
    .O_Valid     (O_Valid),
    .O_Key_Pulse (O_Key_Pulse),
    .O_Data      (O_Data)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    I_Col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !O_Row[r])
          I_Col[c] = 1'b0;
  end

  always @(posedge Clk)
    if (O_Key_Pulse === 1'b1)
      pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_pulse(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge Clk);
      if (O_Key_Pulse === 1'b1)
        got = 1'b1;
    end
  endtask

  // Returns at the negedge right after O_Row switches to the given row.
  task automatic align_row(input logic [3:0] row, output bit got);
    int n;
    n = 0;
    while (O_Row === row && n < 100) begin
      @(negedge Clk);
      n++;
    end
    while (O_Row !== row && n < 100) begin
      @(negedge Clk);
      n++;
    end
    got = (n < 100);
  endtask

  initial begin
    row_seq[0] = 4'b1110; row_seq[1] = 4'b1101; row_seq[2] = 4'b1011; row_seq[3] = 4'b0111;
    seq_code[0] = 4'h1; seq_r[0] = 0; seq_c[0] = 0;
    seq_code[1] = 4'h2; seq_r[1] = 0; seq_c[1] = 1;
    seq_code[2] = 4'h3; seq_r[2] = 0; seq_c[2] = 2;
    seq_code[3] = 4'hA; seq_r[3] = 0; seq_c[3] = 3;
    seq_code[4] = 4'h4; seq_r[4] = 1; seq_c[4] = 0;
    seq_code[5] = 4'h5; seq_r[5] = 1; seq_c[5] = 1;
    seq_code[6] = 4'h6; seq_r[6] = 1; seq_c[6] = 2;
    seq_code[7] = 4'hB; seq_r[7] = 1; seq_c[7] = 3;
    seq_code[8] = 4'h7; seq_r[8] = 2; seq_c[8] = 0;

    Reset = 1'b1;
    Cs    = 1'b0;
    Clr   = 1'b0;
    keys  = 16'h0;
    step(2);
    check("rst_row",   32'(O_Row), 32'h0000_000E);
    check("rst_key",   32'(O_Key), 32'h0);
    check("rst_valid", 32'(O_Valid), 32'h0);
    check("rst_pulse", 32'(O_Key_Pulse), 32'h0);
    check("rst_data",  O_Data, 32'h0);
    Reset = 1'b0;

    // Idle scan: row index advances every 4 clocks after reset release.
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      check($sformatf("idle_row_%0d", k), 32'(O_Row), 32'(row_seq[(k/4)%4]));
    end
    check("idle_pulses", 32'(pulse_cnt), 32'h0);
    check("idle_valid",  32'(O_Valid), 32'h0);
    check("idle_data",   O_Data, 32'h0);

    // Single key 6 (row1/col2), held then released.
    base = pulse_cnt;
    keys = 16'h0040;
    wait_pulse(60, ok);
    check("k6_seen",  32'(ok), 32'h1);
    check("k6_key",   32'(O_Key), 32'h6);
    check("k6_valid", 32'(O_Valid), 32'h1);
    check("k6_data",  O_Data, 32'h0000_0006);
    check("k6_row_held", 32'(O_Row), 32'h0000_000D);
    step(39);
    keys = 16'h0;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge Clk);
      if (O_Row !== 4'b1101)
        ok = 1'b1;
    end
    check("k6_scan_resume", 32'(ok), 32'h1);
    step(10);
    check("k6_one_pulse", 32'(pulse_cnt - base), 32'h1);

    // Nine-key entry sequence shifts the 6 and the 1 out of the register.
    base = pulse_cnt;
    for (int i = 0; i < 9; i++) begin
      keys = 16'h0;
      keys[seq_r[i]*4+seq_c[i]] = 1'b1;
      wait_pulse(60, ok);
      check($sformatf("seq%0d_seen", i), 32'(ok), 32'h1);
      check($sformatf("seq%0d_key", i), 32'(O_Key), 32'(seq_code[i]));
      step(8);
      keys = 16'h0;
      step(30);
    end
    check("seq_data",   O_Data, 32'h23A4_56B7);
    check("seq_pulses", 32'(pulse_cnt - base), 32'h9);

    Clr = 1'b1;
    step(1);
    Clr = 1'b0;
    check("clr_data", O_Data, 32'h0);
    check("clr_key",  32'(O_Key), 32'h7);

    // Bounce on row2/col0: low for one tick only, then high.
    base = pulse_cnt;
    align_row(4'b1011, ok);
    check("bounce_align", 32'(ok), 32'h1);
    keys = 16'h0100;
    step(4);
    keys = 16'h0;
    step(4);
    check("bounce_row_kept", 32'(O_Row), 32'h0000_000B);
    step(4);
    check("bounce_row_next", 32'(O_Row), 32'h0000_0007);
    check("bounce_no_pulse", 32'(pulse_cnt - base), 32'h0);

    // Same key stable: accept lands exactly 12 clocks after the row is selected.
    align_row(4'b1011, ok);
    check("stable_align", 32'(ok), 32'h1);
    keys = 16'h0100;
    step(12);
    check("stable_pulse", 32'(O_Key_Pulse), 32'h1);
    check("stable_key",   32'(O_Key), 32'h7);
    check("stable_data",  O_Data, 32'h0000_0007);
    step(8);
    keys = 16'h0;
    step(30);

    Cs = 1'b1;
    step(1);
    Cs = 1'b0;
    check("cs_clears_valid", 32'(O_Valid), 32'h0);

    // Cs and Clr coincident with the accepting tick of key C (row2/col3).
    align_row(4'b1011, ok);
    check("cs_align", 32'(ok), 32'h1);
    keys = 16'h0800;
    step(11);
    Cs  = 1'b1;
    Clr = 1'b1;
    step(1);
    Cs  = 1'b0;
    Clr = 1'b0;
    check("cs_acc_pulse", 32'(O_Key_Pulse), 32'h1);
    check("cs_acc_valid", 32'(O_Valid), 32'h1);
    check("cs_acc_key",   32'(O_Key), 32'hC);
    check("clr_acc_data", O_Data, 32'h0000_000C);
    Cs = 1'b1;
    step(1);
    Cs = 1'b0;
    check("cs_late_valid", 32'(O_Valid), 32'h0);
    check("cs_late_key",   32'(O_Key), 32'hC);
    check("cs_late_data",  O_Data, 32'h0000_000C);
    step(8);
    keys = 16'h0;
    step(30);

    // Two keys in row0 (cols 1 and 3): lowest column wins.
    base = pulse_cnt;
    keys = 16'h000A;
    wait_pulse(60, ok);
    check("multi_seen", 32'(ok), 32'h1);
    check("multi_key",  32'(O_Key), 32'h2);
    step(20);
    check("multi_one_pulse", 32'(pulse_cnt - base), 32'h1);

    // Reset while HELD with the keys still down.
    Reset = 1'b1;
    #1;
    check("midrst_row",   32'(O_Row), 32'h0000_000E);
    check("midrst_key",   32'(O_Key), 32'h0);
    check("midrst_valid", 32'(O_Valid), 32'h0);
    check("midrst_pulse", 32'(O_Key_Pulse), 32'h0);
    check("midrst_data",  O_Data, 32'h0);
    step(2);
    Reset = 1'b0;
    base = pulse_cnt;
    wait_pulse(60, ok);
    check("postrst_seen",  32'(ok), 32'h1);
    check("postrst_key",   32'(O_Key), 32'h2);
    check("postrst_valid", 32'(O_Valid), 32'h1);
    check("postrst_data",  O_Data, 32'h0000_0002);
    step(10);
    keys = 16'h0;
    step(30);
    check("postrst_one_pulse", 32'(pulse_cnt - base), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
